// File: rtl/ethernet_receiver_pkg.sv
// ethernet_receiver_pkg: shared receive-path types, op sizes and tkeep popcount
package ethernet_receiver_pkg;

    typedef enum logic [1:0] {eIdle, eRecv, eDrop} rx_state_e;

    localparam logic [1:0] op_size_32_c = 2'b10;
    localparam logic [1:0] op_size_64_c = 2'b11;

    function automatic logic [3:0] popcount(input logic [7:0] keep);
        popcount = '0;
        for (int i = 0; i < 8; i++) popcount = popcount + {3'b0, keep[i]};
    endfunction

endpackage

// File: rtl/ethernet_receiver_packet_buffer.sv
// packet_buffer: multi-slot frame store, written per slot and released in FIFO order
module packet_buffer
    import ethernet_receiver_pkg::*;
#(
    parameter int slot_p               = 2,
    parameter int data_width_p         = 64,
    parameter int buf_size_p           = 2048,
    localparam int packet_size_width_lp = $clog2(buf_size_p) + 1,
    localparam int addr_width_lp        = $clog2(buf_size_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    output logic                            write_slot_ready_o,
    input  logic                            write_v_i,
    input  logic [addr_width_lp-1:0]        write_addr_i,
    input  logic [1:0]                      write_op_size_i,
    input  logic [data_width_p-1:0]         write_data_i,
    input  logic                            write_size_v_i,
    input  logic [packet_size_width_lp-1:0] write_size_i,
    input  logic                            write_slot_v_i,
    output logic                            read_slot_v_o,
    output logic [packet_size_width_lp-1:0] read_size_o,
    input  logic                            read_slot_ready_and_i,
    input  logic                            read_v_i,
    input  logic [addr_width_lp-1:0]        read_addr_i,
    output logic [data_width_p-1:0]         read_data_o
);

    localparam int bytes_lp = data_width_p / 8;
    localparam int sh_lp    = $clog2(bytes_lp);
    localparam int words_lp = buf_size_p / bytes_lp;
    localparam int iw_lp    = addr_width_lp - sh_lp;
    localparam int sw_lp    = $clog2(slot_p);

    logic [data_width_p-1:0]         mem_q [slot_p*words_lp];
    logic [packet_size_width_lp-1:0] size_q [slot_p];
    logic [sw_lp-1:0]                wr_slot_q, rd_slot_q;
    logic [sw_lp:0]                  count_q;
    logic [data_width_p-1:0]         rd_data_q;
    logic [addr_width_lp-1:0]        wr_word;
    logic                            pop;

    assign wr_word            = write_addr_i >> write_op_size_i;
    assign write_slot_ready_o = count_q != (sw_lp+1)'(slot_p);
    assign read_slot_v_o      = count_q != '0;
    assign read_size_o        = size_q[rd_slot_q];
    assign read_data_o        = rd_data_q;
    assign pop                = read_slot_v_o && read_slot_ready_and_i;

    // Slot bookkeeping: write/read slot pointers, occupancy, stored sizes and read register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            for (int i = 0; i < slot_p; i++) size_q[i] <= '0;
        end else begin
            wr_slot_q <= wr_slot_q + sw_lp'(write_slot_v_i);
            rd_slot_q <= rd_slot_q + sw_lp'(pop);
            count_q   <= count_q + (sw_lp+1)'(write_slot_v_i) - (sw_lp+1)'(pop);
            if (write_size_v_i) size_q[wr_slot_q] <= write_size_i;
            if (read_v_i) rd_data_q <= mem_q[{rd_slot_q, read_addr_i[addr_width_lp-1:sh_lp]}];
        end
    end

    // Frame storage; contents are don't-care until written so no reset
    always_ff @(posedge clk_i) begin
        if (write_v_i) mem_q[{wr_slot_q, wr_word[iw_lp-1:0]}] <= write_data_i;
    end

endmodule

// File: rtl/ethernet_receiver.sv
// ethernet_receiver: AXI-Stream frame sink that commits good frames into a two-slot buffer
module ethernet_receiver
    import ethernet_receiver_pkg::*;
#(
    parameter int buf_size_p            = 2048,
    parameter int recv_width_p          = 64,
    localparam int packet_size_width_lp = $clog2(buf_size_p) + 1,
    localparam int addr_width_lp        = $clog2(buf_size_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [recv_width_p-1:0]         rx_axis_tdata_i,
    input  logic [recv_width_p/8-1:0]       rx_axis_tkeep_i,
    input  logic                            rx_axis_tvalid_i,
    input  logic                            rx_axis_tlast_i,
    input  logic                            rx_axis_tuser_i,
    output logic                            rx_axis_tready_o,
    output logic                            packet_avail_o,
    output logic [packet_size_width_lp-1:0] packet_size_o,
    input  logic                            packet_ack_i,
    input  logic                            buffer_read_v_i,
    input  logic [addr_width_lp-1:0]        buffer_read_addr_i,
    output logic [recv_width_p-1:0]         buffer_read_data_o,
    output logic [15:0]                     receive_count_o,
    output logic [15:0]                     drop_count_o
);

    localparam int sh_lp = $clog2(recv_width_p / 8);
    localparam int iw_lp = addr_width_lp - sh_lp;
    localparam logic [1:0] op_size_lp = (recv_width_p == 64) ? op_size_64_c : op_size_32_c;

    rx_state_e                       state_q, state_d;
    logic [iw_lp-1:0]                wr_ptr_q, wr_ptr_d;
    logic [packet_size_width_lp-1:0] byte_cnt_q, byte_cnt_d, kcnt, sum;
    logic                            bad_q, bad_d;
    logic [15:0]                     recv_cnt_q, drop_cnt_q;
    logic                            slot_ready, accept, over, wr_v, good, drop;

    assign rx_axis_tready_o = 1'b1;
    assign receive_count_o  = recv_cnt_q;
    assign drop_count_o     = drop_cnt_q;

    // Frame FSM and write pointer / byte count registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= eIdle;
            wr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            bad_q      <= 1'b0;
            recv_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            bad_q      <= bad_d;
            recv_cnt_q <= recv_cnt_q + 16'(good);
            drop_cnt_q <= drop_cnt_q + 16'(drop);
        end
    end

    // A first beat in eIdle with a free slot behaves exactly like an eRecv beat since the pointers are already clear
    always_comb begin
        kcnt       = packet_size_width_lp'(popcount(8'(rx_axis_tkeep_i)));
        sum        = byte_cnt_q + kcnt;
        over       = sum > packet_size_width_lp'(buf_size_p);
        accept     = rx_axis_tvalid_i && ((state_q == eIdle && slot_ready) || state_q == eRecv);
        wr_v       = accept && !bad_q && !over;
        good       = wr_v && rx_axis_tlast_i && !rx_axis_tuser_i && sum != '0;
        drop       = rx_axis_tvalid_i && rx_axis_tlast_i && !good;
        state_d    = !rx_axis_tvalid_i ? state_q : rx_axis_tlast_i ? eIdle : accept ? eRecv : eDrop;
        wr_ptr_d   = (accept && rx_axis_tlast_i) ? '0 : wr_v ? wr_ptr_q + 1'b1 : wr_ptr_q;
        byte_cnt_d = (accept && rx_axis_tlast_i) ? '0 : wr_v ? sum : byte_cnt_q;
        bad_d      = (accept && rx_axis_tlast_i) ? 1'b0 : (accept && over) ? 1'b1 : bad_q;
    end

    packet_buffer #(
        .slot_p       (2),
        .data_width_p (recv_width_p),
        .buf_size_p   (buf_size_p)
    ) buffer (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .write_slot_ready_o    (slot_ready),
        .write_v_i             (wr_v),
        .write_addr_i          ({wr_ptr_q, {sh_lp{1'b0}}}),
        .write_op_size_i       (op_size_lp),
        .write_data_i          (rx_axis_tdata_i),
        .write_size_v_i        (good),
        .write_size_i          (sum),
        .write_slot_v_i        (good),
        .read_slot_v_o         (packet_avail_o),
        .read_size_o           (packet_size_o),
        .read_slot_ready_and_i (packet_ack_i),
        .read_v_i              (buffer_read_v_i),
        .read_addr_i           (buffer_read_addr_i),
        .read_data_o           (buffer_read_data_o)
    );

endmodule

// File: tb/tb_ethernet_receiver.sv
// tb_ethernet_receiver: directed scenario checks of the receive path in 64-bit mode
module tb_ethernet_receiver;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [63:0] rx_axis_tdata_i = '0;
    logic [7:0]  rx_axis_tkeep_i = '0;
    logic        rx_axis_tvalid_i = 1'b0;
    logic        rx_axis_tlast_i = 1'b0;
    logic        rx_axis_tuser_i = 1'b0;
    logic        rx_axis_tready_o;
    logic        packet_avail_o;
    logic [11:0] packet_size_o;
    logic        packet_ack_i = 1'b0;
    logic        buffer_read_v_i = 1'b0;
    logic [10:0] buffer_read_addr_i = '0;
    logic [63:0] buffer_read_data_o;
    logic [15:0] receive_count_o;
    logic [15:0] drop_count_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    ethernet_receiver dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .rx_axis_tdata_i    (rx_axis_tdata_i),
        .rx_axis_tkeep_i    (rx_axis_tkeep_i),
        .rx_axis_tvalid_i   (rx_axis_tvalid_i),
        .rx_axis_tlast_i    (rx_axis_tlast_i),
        .rx_axis_tuser_i    (rx_axis_tuser_i),
        .rx_axis_tready_o   (rx_axis_tready_o),
        .packet_avail_o     (packet_avail_o),
        .packet_size_o      (packet_size_o),
        .packet_ack_i       (packet_ack_i),
        .buffer_read_v_i    (buffer_read_v_i),
        .buffer_read_addr_i (buffer_read_addr_i),
        .buffer_read_data_o (buffer_read_data_o),
        .receive_count_o    (receive_count_o),
        .drop_count_o       (drop_count_o)
    );

    function automatic logic [63:0] word(input int s, input int i);
        return {32'(s), 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        rx_axis_tvalid_i = 1'b0;
        packet_ack_i = 1'b0;
        buffer_read_v_i = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;
    endtask

    task automatic send_frame(input int nbytes, input int seed, input bit err);
        int beats;
        int rem;
        beats = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
        for (int i = 0; i < beats; i++) begin
            rem = nbytes - 8 * i;
            rx_axis_tvalid_i = 1'b1;
            rx_axis_tdata_i  = word(seed, i);
            rx_axis_tkeep_i  = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            rx_axis_tlast_i  = (i == beats - 1);
            rx_axis_tuser_i  = (i == beats - 1) && err;
            tick();
        end
        rx_axis_tvalid_i = 1'b0;
        rx_axis_tlast_i  = 1'b0;
        rx_axis_tuser_i  = 1'b0;
    endtask

    task automatic check_read(input string name, input int addr, input logic [63:0] exp);
        buffer_read_v_i = 1'b1;
        buffer_read_addr_i = 11'(addr);
        tick();
        buffer_read_v_i = 1'b0;
        vectors++;
        if (buffer_read_data_o !== exp) begin
            miscompares++;
            $display("FAIL %s addr=%0d got=%h exp=%h", name, addr, buffer_read_data_o, exp);
        end
    endtask

    task automatic check_status(input string name, input logic av, input logic [11:0] sz,
                                input logic [15:0] rc, input logic [15:0] dc);
        vectors++;
        if (packet_avail_o !== av || (av && packet_size_o !== sz) ||
            receive_count_o !== rc || drop_count_o !== dc) begin
            miscompares++;
            $display("FAIL %s got avail=%b size=%0d recv=%0d drop=%0d exp avail=%b size=%0d recv=%0d drop=%0d",
                     name, packet_avail_o, packet_size_o, receive_count_o, drop_count_o, av, sz, rc, dc);
        end
    endtask

    task automatic ack();
        packet_ack_i = 1'b1;
        tick();
        packet_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (rx_axis_tready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL tready_in_reset got=%b exp=1", rx_axis_tready_o);
        end
        do_reset();
        vectors++;
        if (packet_avail_o !== 1'b0 || packet_size_o !== '0 || receive_count_o !== '0 ||
            drop_count_o !== '0 || buffer_read_data_o !== '0 || rx_axis_tready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_values got avail=%b size=%0d recv=%0d drop=%0d data=%h ready=%b exp all zero, ready=1",
                     packet_avail_o, packet_size_o, receive_count_o, drop_count_o, buffer_read_data_o, rx_axis_tready_o);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        send_frame(60, 1, 1'b0);
        check_status("single_60", 1'b1, 12'd60, 16'd1, 16'd0);
        for (int a = 0; a <= 56; a += 8) check_read("single_read", a, word(1, a / 8));
        tick();
        vectors++;
        if (buffer_read_data_o !== word(1, 7)) begin
            miscompares++;
            $display("FAIL read_hold got=%h exp=%h", buffer_read_data_o, word(1, 7));
        end
        ack();
        check_status("single_acked", 1'b0, 12'd0, 16'd1, 16'd0);
    endtask

    task automatic test_error_frame();
        do_reset();
        send_frame(64, 2, 1'b1);
        check_status("errored", 1'b0, 12'd0, 16'd0, 16'd1);
        send_frame(64, 3, 1'b0);
        check_status("after_error", 1'b1, 12'd64, 16'd1, 16'd1);
        check_read("after_error_w0", 0, word(3, 0));
        check_read("after_error_w7", 56, word(3, 7));
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(100, 4, 1'b0);
        send_frame(100, 5, 1'b0);
        send_frame(100, 6, 1'b0);
        check_status("full_three", 1'b1, 12'd100, 16'd2, 16'd1);
        check_read("full_slot0", 0, word(4, 0));
        ack();
        check_status("full_second", 1'b1, 12'd100, 16'd2, 16'd1);
        check_read("full_slot1", 96, word(5, 12));
        send_frame(100, 7, 1'b0);
        check_status("full_fourth", 1'b1, 12'd100, 16'd3, 16'd1);
        ack();
        check_status("full_fourth_head", 1'b1, 12'd100, 16'd3, 16'd1);
        check_read("full_fourth_read", 8, word(7, 1));
        ack();
        check_status("full_empty", 1'b0, 12'd0, 16'd3, 16'd1);
    endtask

    task automatic test_oversize();
        do_reset();
        send_frame(2056, 8, 1'b0);
        check_status("oversize", 1'b0, 12'd0, 16'd0, 16'd1);
        send_frame(2048, 9, 1'b0);
        check_status("max_size", 1'b1, 12'd2048, 16'd1, 16'd1);
        check_read("max_last", 2040, word(9, 255));
        check_read("max_first", 0, word(9, 0));
    endtask

    task automatic test_small_frames();
        do_reset();
        send_frame(1, 10, 1'b0);
        check_status("one_byte", 1'b1, 12'd1, 16'd1, 16'd0);
        check_read("one_byte_read", 0, word(10, 0));
        send_frame(0, 11, 1'b0);
        check_status("zero_len", 1'b1, 12'd1, 16'd1, 16'd1);
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rx_axis_tvalid_i = 1'b1;
            rx_axis_tdata_i  = word(12, i);
            rx_axis_tkeep_i  = 8'hFF;
            rx_axis_tlast_i  = 1'b0;
            tick();
        end
        rx_axis_tvalid_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        send_frame(20, 13, 1'b0);
        check_status("mid_reset", 1'b1, 12'd20, 16'd1, 16'd0);
        check_read("mid_reset_read", 16, word(13, 2));
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_error_frame();
        test_back_to_back();
        test_oversize();
        test_small_frames();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
